// File: rtl/uart_host_master.sv
// uart_host_master: sends fixed command byte sequences over a UART TX line and
// collects 0..2 response bytes from the UART RX line, reporting completion
// with a one-cycle rsp_valid pulse plus data/error.
module uart_host_master #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PAR_EN       = 1,
    parameter int PAR_TYP      = 0,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_fun,
    output logic        tx_line,
    input  logic        rx_line,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int   FRAME = (PAR_EN != 0) ? 11 : 10;
    localparam int   BW    = $clog2(CLKS_PER_BIT);
    localparam int   TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic PEN   = (PAR_EN != 0);
    localparam logic PTYP  = (PAR_TYP != 0);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
    state_t state, next_state;

    logic [1:0]    op_q;
    logic [7:0]    addr_q, a_q, b_q;
    logic [3:0]    fun_q;
    logic [BW-1:0] tx_baud, rx_baud;
    logic [3:0]    tx_bit, rx_bit;
    logic [1:0]    tx_byte, rx_cnt;
    logic          rx_s1, rx_s2, rx_s3, rx_active;
    logic [7:0]    rx_shift, rx_b0, rx_b1;
    logic [TW-1:0] to_cnt;

    logic       accept, frame_end, send_end, next_bit;
    logic       rx_sample, rx_err, byte_done, last_byte, start_edge, timeout;
    logic [7:0] cur_byte, lo_next, hi_next;
    logic [1:0] tx_last, nrsp;

    // Command decode: outgoing byte for the current index and response length
    always_comb begin
        cur_byte = 8'h00;
        tx_last  = 2'd0;
        nrsp     = 2'd0;
        case (op_q)
            2'd0: begin
                tx_last  = 2'd2;
                cur_byte = (tx_byte == 2'd0) ? 8'hAA : (tx_byte == 2'd1) ? addr_q : a_q;
            end
            2'd1: begin
                tx_last  = 2'd1;
                nrsp     = 2'd1;
                cur_byte = (tx_byte == 2'd0) ? 8'hBB : addr_q;
            end
            2'd2: begin
                tx_last = 2'd3;
                nrsp    = 2'd2;
                case (tx_byte)
                    2'd0:    cur_byte = 8'hCC;
                    2'd1:    cur_byte = a_q;
                    2'd2:    cur_byte = b_q;
                    default: cur_byte = {4'h0, fun_q};
                endcase
            end
            default: begin
                tx_last  = 2'd1;
                nrsp     = 2'd2;
                cur_byte = (tx_byte == 2'd0) ? 8'hDD : {4'h0, fun_q};
            end
        endcase
    end

    // Bit/frame bookkeeping shared by the FSM and the datapath
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        // value of bit tx_bit+1 of the frame being sent
        next_bit  = 1'b1;
        if (tx_bit < 4'd8)
            next_bit = cur_byte[tx_bit[2:0]];
        else if (PEN && tx_bit == 4'd8)
            next_bit = ^cur_byte ^ PTYP;
        frame_end  = (tx_baud == BW'(CLKS_PER_BIT - 1)) && (tx_bit == 4'(FRAME - 1));
        send_end   = (state == SEND) && frame_end && (tx_byte == tx_last);
        rx_sample  = rx_active && (rx_baud == BW'(CLKS_PER_BIT / 2));
        rx_err     = rx_sample &&
                     ((PEN && rx_bit == 4'd9 && rx_s2 != (^rx_shift ^ PTYP)) ||
                      (rx_bit == 4'(FRAME - 1) && !rx_s2));
        byte_done  = rx_sample && (rx_bit == 4'(FRAME - 1)) && rx_s2;
        last_byte  = byte_done && (rx_cnt == nrsp - 2'd1);
        start_edge = (state == WAIT_RSP) && !rx_active && rx_s3 && !rx_s2;
        timeout    = (state == WAIT_RSP) && !rx_active && (to_cnt == TW'(TIMEOUT_CYC - 1));
        lo_next    = (byte_done && rx_cnt == 2'd0) ? rx_shift : rx_b0;
        hi_next    = (byte_done && rx_cnt == 2'd1) ? rx_shift : rx_b1;
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state and status outputs
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        rsp_valid  = (state == DONE);
        case (state)
            IDLE:     if (accept) next_state = SEND;
            SEND:     if (send_end) next_state = (nrsp == 2'd0) ? DONE : WAIT_RSP;
            WAIT_RSP: if (rx_err || timeout || last_byte) next_state = DONE;
            default:  next_state = IDLE;
        endcase
    end

    // Ready is registered so it first rises on the edge after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cmd_ready <= 1'b0;
        else     cmd_ready <= (next_state == IDLE);
    end

    // Command fields captured on accept
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q <= '0; addr_q <= '0; a_q <= '0; b_q <= '0; fun_q <= '0;
        end else if (accept) begin
            op_q <= cmd_op; addr_q <= cmd_addr; a_q <= cmd_a; b_q <= cmd_b; fun_q <= cmd_fun;
        end
    end

    // Transmitter: start bit goes out the cycle after accept, frames back-to-back
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_line <= 1'b1;
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else if (accept) begin
            tx_line <= 1'b0;
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else if (state == SEND) begin
            if (tx_baud == BW'(CLKS_PER_BIT - 1)) begin
                tx_baud <= '0;
                if (tx_bit == 4'(FRAME - 1)) begin
                    tx_bit <= '0;
                    if (tx_byte == tx_last) begin
                        tx_line <= 1'b1;
                    end else begin
                        tx_byte <= tx_byte + 2'd1;
                        tx_line <= 1'b0;
                    end
                end else begin
                    tx_bit  <= tx_bit + 4'd1;
                    tx_line <= next_bit;
                end
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
        end else begin
            tx_line <= 1'b1;
        end
    end

    // RX synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_line; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
        end
    end

    // Receiver: hunt for start, sample mid-bit, collect bytes, run the timeout
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_active <= 1'b0;
            rx_baud   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_cnt    <= '0;
            rx_b0     <= '0;
            rx_b1     <= '0;
            to_cnt    <= '0;
        end else begin
            if (accept) begin
                rx_cnt <= '0;
                rx_b0  <= '0;
                rx_b1  <= '0;
            end
            // to_cnt counts cycles since the last stop bit / last byte end
            if (send_end)
                to_cnt <= TW'(1);
            if (state == WAIT_RSP) begin
                if (!rx_active) begin
                    if (start_edge) begin
                        // the detection cycle is count 0 of the start bit
                        rx_active <= 1'b1;
                        rx_baud   <= BW'(1);
                        rx_bit    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end else begin
                    if (rx_baud == BW'(CLKS_PER_BIT - 1)) begin
                        rx_baud <= '0;
                        rx_bit  <= rx_bit + 4'd1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                    if (rx_sample) begin
                        if (rx_bit == 4'd0 && rx_s2)
                            rx_active <= 1'b0;
                        else if (rx_bit != 4'd0 && rx_bit <= 4'd8)
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                    end
                    if (byte_done) begin
                        rx_active <= 1'b0;
                        to_cnt    <= TW'(1);
                        rx_cnt    <= rx_cnt + 2'd1;
                        rx_b0     <= lo_next;
                        rx_b1     <= hi_next;
                    end
                end
            end
            if (next_state != WAIT_RSP)
                rx_active <= 1'b0;
        end
    end

    // Response registers change only on entry to DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state != DONE && next_state == DONE) begin
            rsp_data <= {hi_next, lo_next};
            rsp_err  <= rx_err || timeout;
        end
    end

endmodule

// File: doc/uart_host_master.md
UART_HOST_MASTER -- requirements
Module: uart_host_master

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, CLK cycles per UART bit (>=8).
REQ-002 Parameter: PAR_EN, 1, parity bit present in every frame, both directions.
REQ-003 Parameter: PAR_TYP, 0, 0 = even parity, 1 = odd parity.
REQ-004 Parameter: TIMEOUT_CYC, 4096, maximum idle cycles while waiting for a response start bit.
REQ-005 One clock; reset is asynchronous and active-high. Ports: CLK in 1, clock; RST in 1, asynchronous active-high reset.
REQ-006 Port: cmd_valid in 1, command request.
REQ-007 Port: cmd_ready out 1, command accepted when cmd_valid && cmd_ready.
REQ-008 Port: cmd_op in 2, 0 = REG_WR, 1 = REG_RD, 2 = ALU_OPER, 3 = ALU_NOPER.
REQ-009 Ports: cmd_addr in 8; cmd_a in 8; cmd_b in 8; cmd_fun in 4 (command fields).
REQ-010 Port: tx_line out 1, serial line to the system RX_IN; idles high.
REQ-011 Port: rx_line in 1, serial line from the system TX_OUT; asynchronous to CLK.
REQ-012 Ports: rsp_valid out 1, one-cycle completion pulse; rsp_data out 16, response (LSB byte first received in [7:0]); rsp_err out 1, qualified by rsp_valid.
REQ-013 Port: busy out 1, high from command accept until the rsp_valid cycle inclusive.

Function
REQ-014 FSM states: IDLE, SEND, WAIT_RSP, DONE. cmd_ready = 1 only in IDLE.
- IDLE->SEND on accept.
- SEND->WAIT_RSP after the last stop bit, or SEND->DONE if 0 response bytes.
- WAIT_RSP->DONE when all bytes are received, or on error.
- DONE->IDLE after 1 cycle.
REQ-015 All cmd_* fields are registered on accept; later changes have no effect.
REQ-016 Byte sequences:
- REG_WR: 0xAA, addr, a.
- REG_RD: 0xBB, addr.
- ALU_OPER: 0xCC, a, b, {4'h0, fun}.
- ALU_NOPER: 0xDD, {4'h0, fun}.
REQ-017 Response byte count: REG_WR 0, REG_RD 1, ALU_* 2; for ALU the first byte -> rsp_data[7:0], the second -> rsp_data[15:8].
REQ-018 Frame format: start 0, D0..D7 LSB first, parity bit (if PAR_EN), stop 1; each bit lasts exactly CLKS_PER_BIT cycles; frames are sent back-to-back with no extra idle.
REQ-019 The first start bit is driven on the cycle after accept; the total SEND duration is nbytes*(10+PAR_EN)*CLKS_PER_BIT cycles.
REQ-020 Receive path:
- rx_line passes through a 2-flop synchronizer.
- A start is a synchronized falling edge.
- Each bit is sampled at count CLKS_PER_BIT/2 within the bit.
- A start sample of 1 is a false start: return to hunting, no error.
REQ-021 Receive error checks: parity mismatch, or stop sample 0 -> rsp_err=1, immediate DONE.
REQ-022 Timeout: a counter runs in WAIT_RSP while hunting for a start bit and reloads at each byte end; reaching TIMEOUT_CYC -> rsp_err=1, DONE.
REQ-023 rx_line activity in IDLE or SEND is ignored.
REQ-024 rsp_data and rsp_err update only in DONE and hold until the next DONE; unreceived bytes read 0.
REQ-025 Results: REG_WR completes with rsp_data=0 and rsp_err=0; rsp_valid asserts in DONE only.

Reset
REQ-026 While RST=1:
- tx_line=1, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- FSM=IDLE; all bit, baud and timeout counters = 0.
REQ-027 Reset mid-frame aborts immediately with no partial response; cmd_ready=1 on the first CLK edge after RST falls.

Verification
REQ-028 REG_WR addr=0x02 a=0x81 (defaults) -> frames 0xAA (P=0), 0x02 (P=1), 0x81 (P=0); busy for 528 cycles then rsp_valid with rsp_err=0, rsp_data=0x0000.
REQ-029 REG_RD addr=0x00, bench replies 0x5C with correct parity -> rsp_valid, rsp_data=0x005C, rsp_err=0.
REQ-030 ALU_OPER a=0x0A b=0x03 fun=0, bench replies 0x0D then 0x00 -> rsp_data=0x000D; PAR_TYP=1 rerun -> all parity bits inverted.
REQ-031 REG_RD, bench reply has the parity bit flipped -> rsp_err=1, rsp_data=0x0000; 1-cycle glitch low on rx_line -> no error, reply still decoded.
REQ-032 REG_RD, no reply -> rsp_valid with rsp_err=1 exactly TIMEOUT_CYC cycles after the last stop bit; cmd_ready=1 the next cycle.
REQ-033 RST pulsed during the second byte of ALU_OPER -> tx_line=1 immediately, no rsp_valid; a new REG_WR afterwards sends a correct 0xAA frame.
